// File: rtl/sm4_key_schedule_ctrl.sv
// sm4_key_schedule_ctrl
//   Drives an external single-round SM4 key expander through 32 rounds,
//   keeps the resulting round keys rk[0..31] in a local register file and
//   then serves them to the round datapath as a valid/ready stream,
//   ascending (encrypt) or descending (decrypt).
//
// Ports
//   i_clk, i_rst        clock (rising edge) / synchronous active-low reset
//   i_key, i_key_valid  128-bit user key MK0..MK3 (MK0 in [127:96]) and load strobe
//   o_key_ready         a new key can be accepted
//   o_ext_*             request to the expander (round index, 128-bit state, pulse)
//   i_ext_*             expander result (round key, next state, strobe)
//   o_sched_done        all 32 round keys stored
//   o_err_timeout       expander did not answer within TIMEOUT_CYC cycles
//   i_rk_start/i_rk_decrypt  start a stream and choose its direction
//   o_rk, o_rk_index, o_rk_valid, i_rk_ready, o_rk_last  round-key stream
module sm4_key_schedule_ctrl #(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [127:0] i_key,
  input  logic         i_key_valid,
  output logic         o_key_ready,
  output logic [7:0]   o_ext_i,
  output logic [127:0] o_ext_key,
  output logic         o_ext_valid,
  input  logic [31:0]  i_ext_key,
  input  logic [127:0] i_ext_K,
  input  logic         i_ext_valid,
  output logic         o_sched_done,
  output logic         o_err_timeout,
  input  logic         i_rk_start,
  input  logic         i_rk_decrypt,
  output logic [31:0]  o_rk,
  output logic [4:0]   o_rk_index,
  output logic         o_rk_valid,
  input  logic         i_rk_ready,
  output logic         o_rk_last
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    DONE  = 3'd3,
    ERR   = 3'd4
  } state_t;

  state_t          state_r, state_s;
  logic [127:0]    s_r, s_s;        // expander state, issued as o_ext_key
  logic [4:0]      r_r, r_s;        // current round
  logic [TW-1:0]   tcnt_r, tcnt_s;  // WAIT cycles without a result
  logic [TW-1:0]   tcnt_inc_s;
  logic            act_r, act_s;    // stream in progress
  logic            dec_r, dec_s;    // stream direction, 1 = descending
  logic [4:0]      p_r, p_s;        // stream pointer
  logic            rk_wr_s;
  logic            key_ready_s;
  logic            key_acc_s;
  logic            last_s;
  logic [31:0]     rk_mem [32];

  // A key load is refused while a stream is draining so old keys never get
  // mixed with a schedule that is overwriting them.
  assign key_ready_s = (state_r == IDLE) || (state_r == ERR) ||
                       ((state_r == DONE) && !act_r);
  assign key_acc_s   = i_key_valid && key_ready_s;
  assign tcnt_inc_s  = tcnt_r + {{(TW-1){1'b0}}, 1'b1};
  assign last_s      = act_r && (dec_r ? (p_r == 5'd0) : (p_r == 5'd31));

  // Next-state and datapath update for the schedule FSM and the stream pointer
  always_comb begin
    state_s = state_r;
    s_s     = s_r;
    r_s     = r_r;
    tcnt_s  = tcnt_r;
    act_s   = act_r;
    dec_s   = dec_r;
    p_s     = p_r;
    rk_wr_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (key_acc_s) begin
          state_s = ISSUE;
          s_s     = i_key;
          r_s     = 5'd0;
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE: begin
        state_s = WAIT;
        tcnt_s  = {TW{1'b0}};
      end
      WAIT: begin
        if (i_ext_valid) begin
          rk_wr_s = 1'b1;
          s_s     = i_ext_K;
          if (r_r == 5'd31) begin
            state_s = DONE;
          end else begin
            r_s     = r_r + 5'd1;
            state_s = ISSUE;
          end
        end else if (tcnt_inc_s == TW'(TIMEOUT_CYC)) begin
          state_s = ERR;
        end else begin
          tcnt_s = tcnt_inc_s;
        end
      end
      DONE: begin
        if (key_acc_s) begin
          state_s = ISSUE;
          s_s     = i_key;
          r_s     = 5'd0;
        end else if (act_r) begin
          if (i_rk_ready) begin
            if (last_s) begin
              act_s = 1'b0;
            end else if (dec_r) begin
              p_s = p_r - 5'd1;
            end else begin
              p_s = p_r + 5'd1;
            end
          end else begin
            p_s = p_r;
          end
        end else if (i_rk_start) begin
          act_s = 1'b1;
          dec_s = i_rk_decrypt;
          p_s   = i_rk_decrypt ? 5'd31 : 5'd0;
        end else begin
          act_s = 1'b0;
        end
      end
      ERR: begin
        if (key_acc_s) begin
          state_s = ISSUE;
          s_s     = i_key;
          r_s     = 5'd0;
        end else begin
          state_s = ERR;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and control registers with synchronous active-low reset
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_r <= IDLE;
      s_r     <= 128'd0;
      r_r     <= 5'd0;
      tcnt_r  <= {TW{1'b0}};
      act_r   <= 1'b0;
      dec_r   <= 1'b0;
      p_r     <= 5'd0;
    end else begin
      state_r <= state_s;
      s_r     <= s_s;
      r_r     <= r_s;
      tcnt_r  <= tcnt_s;
      act_r   <= act_s;
      dec_r   <= dec_s;
      p_r     <= p_s;
    end
  end

  // Round-key storage; left unreset because it is only read once DONE is reached
  always_ff @(posedge i_clk) begin
    if (rk_wr_s) begin
      rk_mem[r_r] <= i_ext_key;
    end
  end

  // Outputs decode registered state only; o_ext_i/o_ext_key hold through WAIT
  // because r_r and s_r only move when a result is captured.
  assign o_key_ready   = key_ready_s;
  assign o_ext_valid   = (state_r == ISSUE);
  assign o_ext_i       = {3'b000, r_r};
  assign o_ext_key     = s_r;
  assign o_sched_done  = (state_r == DONE);
  assign o_err_timeout = (state_r == ERR);
  assign o_rk_valid    = act_r;
  assign o_rk          = act_r ? rk_mem[p_r] : 32'd0;
  assign o_rk_index    = act_r ? p_r : 5'd0;
  assign o_rk_last     = last_s;

endmodule

// File: tb/tb_sm4_key_schedule_ctrl.sv
// tb_sm4_key_schedule_ctrl
//   Directed bench for sm4_key_schedule_ctrl with an SM4 key-expander model
//   of latency 4 (result sampled 4 edges after the request is sampled).
module tb_sm4_key_schedule_ctrl;

  localparam logic [127:0] STD_KEY = 128'h0123456789ABCDEFFEDCBA9876543210;
  localparam logic [127:0] FK      = 128'hA3B1BAC656AA3350677D9197B27022DC;
  localparam int           LAT     = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [127:0] key = 128'd0;
  logic         key_valid = 1'b0;
  logic         key_ready;
  logic [7:0]   ext_i;
  logic [127:0] ext_key;
  logic         ext_valid;
  logic [31:0]  ext_rk_in;
  logic [127:0] ext_k_in;
  logic         ext_valid_in;
  logic         sched_done;
  logic         err_timeout;
  logic         rk_start = 1'b0;
  logic         rk_decrypt = 1'b0;
  logic [31:0]  rk;
  logic [4:0]   rk_index;
  logic         rk_valid;
  logic         rk_ready = 1'b0;
  logic         rk_last;

  // expander model state
  logic         m_valid = 1'b0;
  logic [31:0]  m_rk = 32'd0;
  logic [127:0] m_K = 128'd0;
  logic         stray_v = 1'b0;
  logic         model_en = 1'b1;
  logic [7:0]   sbox [256];
  logic [31:0]  exp_rk [32];
  int           hold_bad = 0;

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  assign ext_valid_in = m_valid | stray_v;
  assign ext_rk_in    = stray_v ? 32'hDEADBEEF : m_rk;
  assign ext_k_in     = stray_v ? {4{32'hA5A5A5A5}} : m_K;

  sm4_key_schedule_ctrl #(.TIMEOUT_CYC(16)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_key(key), .i_key_valid(key_valid), .o_key_ready(key_ready),
    .o_ext_i(ext_i), .o_ext_key(ext_key), .o_ext_valid(ext_valid),
    .i_ext_key(ext_rk_in), .i_ext_K(ext_k_in), .i_ext_valid(ext_valid_in),
    .o_sched_done(sched_done), .o_err_timeout(err_timeout),
    .i_rk_start(rk_start), .i_rk_decrypt(rk_decrypt),
    .o_rk(rk), .o_rk_index(rk_index), .o_rk_valid(rk_valid),
    .i_rk_ready(rk_ready), .o_rk_last(rk_last)
  );

  always #5 clk = ~clk;

  initial begin
    sbox = '{
      8'hd6,8'h90,8'he9,8'hfe,8'hcc,8'he1,8'h3d,8'hb7,8'h16,8'hb6,8'h14,8'hc2,8'h28,8'hfb,8'h2c,8'h05,
      8'h2b,8'h67,8'h9a,8'h76,8'h2a,8'hbe,8'h04,8'hc3,8'haa,8'h44,8'h13,8'h26,8'h49,8'h86,8'h06,8'h99,
      8'h9c,8'h42,8'h50,8'hf4,8'h91,8'hef,8'h98,8'h7a,8'h33,8'h54,8'h0b,8'h43,8'hed,8'hcf,8'hac,8'h62,
      8'he4,8'hb3,8'h1c,8'ha9,8'hc9,8'h08,8'he8,8'h95,8'h80,8'hdf,8'h94,8'hfa,8'h75,8'h8f,8'h3f,8'ha6,
      8'h47,8'h07,8'ha7,8'hfc,8'hf3,8'h73,8'h17,8'hba,8'h83,8'h59,8'h3c,8'h19,8'he6,8'h85,8'h4f,8'ha8,
      8'h68,8'h6b,8'h81,8'hb2,8'h71,8'h64,8'hda,8'h8b,8'hf8,8'heb,8'h0f,8'h4b,8'h70,8'h56,8'h9d,8'h35,
      8'h1e,8'h24,8'h0e,8'h5e,8'h63,8'h58,8'hd1,8'ha2,8'h25,8'h22,8'h7c,8'h3b,8'h01,8'h21,8'h78,8'h87,
      8'hd4,8'h00,8'h46,8'h57,8'h9f,8'hd3,8'h27,8'h52,8'h4c,8'h36,8'h02,8'he7,8'ha0,8'hc4,8'hc8,8'h9e,
      8'hea,8'hbf,8'h8a,8'hd2,8'h40,8'hc7,8'h38,8'hb5,8'ha3,8'hf7,8'hf2,8'hce,8'hf9,8'h61,8'h15,8'ha1,
      8'he0,8'hae,8'h5d,8'ha4,8'h9b,8'h34,8'h1a,8'h55,8'had,8'h93,8'h32,8'h30,8'hf5,8'h8c,8'hb1,8'he3,
      8'h1d,8'hf6,8'he2,8'h2e,8'h82,8'h66,8'hca,8'h60,8'hc0,8'h29,8'h23,8'hab,8'h0d,8'h53,8'h4e,8'h6f,
      8'hd5,8'hdb,8'h37,8'h45,8'hde,8'hfd,8'h8e,8'h2f,8'h03,8'hff,8'h6a,8'h72,8'h6d,8'h6c,8'h5b,8'h51,
      8'h8d,8'h1b,8'haf,8'h92,8'hbb,8'hdd,8'hbc,8'h7f,8'h11,8'hd9,8'h5c,8'h41,8'h1f,8'h10,8'h5a,8'hd8,
      8'h0a,8'hc1,8'h31,8'h88,8'ha5,8'hcd,8'h7b,8'hbd,8'h2d,8'h74,8'hd0,8'h12,8'hb8,8'he5,8'hb4,8'hb0,
      8'h89,8'h69,8'h97,8'h4a,8'h0c,8'h96,8'h77,8'h7e,8'h65,8'hb9,8'hf1,8'h09,8'hc5,8'h6e,8'hc6,8'h84,
      8'h18,8'hf0,8'h7d,8'hec,8'h3a,8'hdc,8'h4d,8'h20,8'h79,8'hee,8'h5f,8'h3e,8'hd7,8'hcb,8'h39,8'h48};
  end

  // One SM4 key-expansion round: returns {next state, round key}
  function automatic logic [159:0] sm4_round(input logic [7:0] idx, input logic [127:0] k);
    logic [127:0] kk;
    logic [31:0]  ck, x, b, t, rkv;
    kk = (idx == 8'd0) ? (k ^ FK) : k;
    for (int j = 0; j < 4; j++) ck[31-8*j -: 8] = 8'(((4 * int'(idx)) + j) * 7);
    x = kk[95:64] ^ kk[63:32] ^ kk[31:0] ^ ck;
    for (int j = 0; j < 4; j++) b[8*j +: 8] = sbox[x[8*j +: 8]];
    t = b ^ {b[18:0], b[31:19]} ^ {b[8:0], b[31:9]};
    rkv = kk[127:96] ^ t;
    return {kk[95:0], rkv, rkv};
  endfunction

  // Expander model: answers LAT edges after the request and watches o_ext_* hold
  always begin : expander
    logic         rst_e;
    logic         busy, hold_chk;
    int           cnt;
    logic [7:0]   cap_i;
    logic [127:0] cap_key;
    logic [159:0] res;
    busy = 1'b0; hold_chk = 1'b0; cnt = 0; cap_i = 8'd0; cap_key = 128'd0;
    forever begin
      @(posedge clk);
      rst_e = rst;
      #1;
      if (m_valid) begin m_valid = 1'b0; busy = 1'b0; hold_chk = 1'b0; end
      if (!rst_e) hold_chk = 1'b0;
      if (busy && hold_chk && ((ext_key !== cap_key) || (ext_i !== cap_i))) hold_bad++;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          res = sm4_round(cap_i, cap_key);
          m_rk = res[31:0];
          m_K = res[159:32];
          exp_rk[cap_i[4:0]] = res[31:0];
          m_valid = 1'b1;
        end
      end
      if (ext_valid && model_en) begin
        cap_i = ext_i; cap_key = ext_key; cnt = LAT; busy = 1'b1; hold_chk = 1'b1;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [191:0] outs();
    return {ext_valid, ext_i, ext_key, sched_done, err_timeout,
            rk_valid, rk, rk_index, rk_last, key_ready};
  endfunction

  task automatic load_key(input logic [127:0] k);
    key = k;
    key_valid = 1'b1;
    cyc();
    key_valid = 1'b0;
    check("load_issue", {ext_valid, ext_i, ext_key, sched_done, key_ready},
          {1'b1, 8'd0, k, 1'b0, 1'b0});
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!sched_done && n < 400) begin cyc(); n++; end
    check(tag, 192'(n), 192'(32 * (LAT + 1)));
    check("done_flags", {sched_done, err_timeout, rk_valid, key_ready}, 4'b1001);
  endtask

  task automatic enc_stream();
    rk_ready = 1'b1;
    rk_decrypt = 1'b0;
    rk_start = 1'b1;
    cyc();
    rk_start = 1'b0;
    for (int i = 0; i < 32; i++) begin
      check("enc_key", {rk_valid, rk_index, rk, rk_last}, {1'b1, 5'(i), exp_rk[i], (i == 31)});
      if (i == 0)  check("rk0_std", rk, 32'hF12186F9);
      if (i == 1)  check("rk1_std", rk, 32'h41662B61);
      if (i == 31) check("rk31_std", rk, 32'h9124A012);
      if (i == 12) check("key_ready_in_stream", key_ready, 1'b0);
      rk_start = (i == 10);
      rk_decrypt = (i == 10);
      key_valid = (i == 12);
      key = ~STD_KEY;
      cyc();
    end
    rk_start = 1'b0;
    rk_decrypt = 1'b0;
    key_valid = 1'b0;
    check("enc_end", {rk_valid, sched_done, key_ready}, 3'b011);
  endtask

  initial begin : main
    int t, hs, exp_idx, n;

    // reset state
    rst = 1'b0;
    cyc(); cyc();
    rst = 1'b1;
    check("reset_state", outs(), 192'd1);

    // stray expander strobe and stream start while IDLE
    stray_v = 1'b1;
    rk_start = 1'b1;
    cyc();
    stray_v = 1'b0;
    rk_start = 1'b0;
    cyc();
    check("idle_stray_ignored", outs(), 192'd1);

    // standard key schedule; a stream start mid-schedule must be ignored
    load_key(STD_KEY);
    n = 0;
    while (!sched_done && n < 400) begin
      rk_start = (n == 20);
      cyc();
      n++;
    end
    rk_start = 1'b0;
    check("done_latency", 192'(n), 192'(32 * (LAT + 1)));
    check("start_before_done_ignored", {sched_done, rk_valid}, 2'b10);

    // stray expander strobe in DONE must not corrupt stored keys
    stray_v = 1'b1;
    cyc();
    stray_v = 1'b0;
    cyc();
    check("done_stray_flags", {sched_done, err_timeout, rk_valid, key_ready}, 4'b1001);

    enc_stream();

    // decrypt stream with i_rk_ready toggling
    rk_decrypt = 1'b1;
    rk_start = 1'b1;
    cyc();
    rk_start = 1'b0;
    rk_decrypt = 1'b0;
    check("dec_valid_after_start", rk_valid, 1'b1);
    exp_idx = 31; hs = 0; t = 0;
    while (rk_valid && t < 100) begin
      rk_ready = ~t[0];
      check("dec_key", {rk_index, rk, rk_last}, {5'(exp_idx), exp_rk[exp_idx], (exp_idx == 0)});
      if (t == 0) check("dec_first_rk31", rk, 32'h9124A012);
      if (rk_ready) begin hs++; exp_idx--; end
      cyc();
      t++;
    end
    rk_ready = 1'b1;
    check("dec_handshakes", 192'(hs), 192'd32);
    check("dec_end", {rk_valid, sched_done}, 2'b01);

    // reload from DONE
    load_key(STD_KEY);
    wait_done("reload_latency");

    // reset mid-stream at index 5
    rk_start = 1'b1;
    cyc();
    rk_start = 1'b0;
    for (int i = 0; i < 5; i++) cyc();
    check("stream_at_5", {rk_valid, rk_index}, {1'b1, 5'd5});
    rst = 1'b0;
    cyc();
    check("reset_mid_stream", outs(), 192'd1);
    rst = 1'b1;

    // reset at round 10, then the in-flight result must be ignored
    load_key(STD_KEY);
    n = 0;
    while (!(ext_valid && (ext_i == 8'd10)) && n < 200) begin cyc(); n++; end
    check("reach_round10", {ext_valid, ext_i}, {1'b1, 8'd10});
    cyc();
    rst = 1'b0;
    cyc();
    check("reset_round10", outs(), 192'd1);
    rst = 1'b1;
    for (int i = 0; i < 8; i++) cyc();
    check("stale_result_ignored", outs(), 192'd1);

    load_key(STD_KEY);
    wait_done("after_reset_latency");
    enc_stream();

    // timeout: expander never answers
    model_en = 1'b0;
    cyc();
    load_key(~STD_KEY);
    for (int i = 0; i < 16; i++) cyc();
    check("no_err_before_timeout", {err_timeout, sched_done}, 2'b00);
    cyc();
    check("timeout_err", {err_timeout, key_ready, ext_valid, sched_done}, 4'b1100);
    model_en = 1'b1;
    cyc();
    load_key(STD_KEY);
    check("err_cleared", err_timeout, 1'b0);
    wait_done("after_err_latency");
    enc_stream();

    check("ext_key_hold", 192'(hold_bad), 192'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/sm4_key_schedule_ctrl.md
# sm4_key_schedule_ctrl

- Sequences the single-round SM4 key expander through all 32 rounds and stores the 32 round keys rk[0..31] in a local register file.
- Serves the stored keys to the SM4 round datapath as a valid/ready stream:
  - ascending order (rk0 first) for encryption;
  - descending order (rk31 first) for decryption.
- Sits between the 128-bit user key input and the expander: it issues one expander request per round and collects each result.

## Interface
Parameters:
- TIMEOUT_CYC, default 16: maximum number of cycles the block waits for an expander result after issuing a request.

Ports:
- i_clk  in  1  clock; all logic is on the rising edge.
- i_rst  in  1  reset; synchronous, active-low (0 = reset).
- i_key  in  128  user key MK0..MK3, with MK0 in bits [127:96].
- i_key_valid  in  1  load request; accepted on a cycle where i_key_valid && o_key_ready.
- o_key_ready  out  1  block can accept a new key.
- o_ext_i  out  8  round index sent to the expander.
- o_ext_key  out  128  128-bit state sent to the expander.
- o_ext_valid  out  1  one-cycle request pulse to the expander.
- i_ext_key  in  32  round key returned by the expander.
- i_ext_K  in  128  next state {K(i+1), K(i+2), K(i+3), rk_i} returned by the expander.
- i_ext_valid  in  1  expander result strobe.
- o_sched_done  out  1  all 32 round keys are stored and valid.
- o_err_timeout  out  1  the expander failed to answer within TIMEOUT_CYC cycles.
- i_rk_start  in  1  start a round-key stream.
- i_rk_decrypt  in  1  stream direction, sampled together with i_rk_start (1 = descending).
- o_rk  out  32  current round key.
- o_rk_index  out  5  index of o_rk.
- o_rk_valid  out  1  o_rk is valid.
- i_rk_ready  in  1  consumer accepts o_rk.
- o_rk_last  out  1  the current o_rk is the final key of the stream.

## Operation
Schedule FSM states: IDLE, ISSUE, WAIT, DONE, ERR.
- IDLE:
  - o_key_ready=1.
  - Key accepted → latch i_key into state register S, set round counter r=0, go to ISSUE.
- ISSUE (one cycle):
  - o_ext_valid=1, o_ext_i=r, o_ext_key=S.
  - Go to WAIT; clear the timeout counter.
- WAIT:
  - o_ext_i and o_ext_key are held stable at the values issued; the expander relies on this.
  - On i_ext_valid:
    - write rk[r]=i_ext_key and S=i_ext_K;
    - if r==31, go to DONE; otherwise r=r+1 and go to ISSUE.
  - If the counter reaches TIMEOUT_CYC with no i_ext_valid, go to ERR.
- Round 0 uses the raw MK; the expander applies FK itself when o_ext_i==0. For r≥1, o_ext_key is the S captured from i_ext_K.
- DONE:
  - o_sched_done=1.
  - o_key_ready=1 only while no stream is active.
  - A new key load clears o_sched_done and restarts the schedule from round 0; the old keys are overwritten progressively and must not be streamed.
- ERR:
  - o_err_timeout=1 and o_key_ready=1.
  - A new key load clears the error and restarts the schedule.
- i_ext_valid outside WAIT is ignored.

Stream (active only in DONE):
- i_rk_start while idle → pointer p = 0 (encrypt) or 31 (decrypt).
- o_rk=rk[p], o_rk_index=p, o_rk_valid=1.
- On each o_rk_valid && i_rk_ready, p steps by +1 or -1.
- o_rk_last=1 when p==31 (encrypt) or p==0 (decrypt).
- The handshake on the last key ends the stream.
- i_rk_start while a stream is active, or outside DONE, is ignored.
- o_rk and o_rk_index must hold stable while o_rk_valid && !i_rk_ready.

## Timing
- Reset values:
  - state=IDLE, so o_key_ready=1;
  - o_ext_valid=0, o_ext_i=0, o_ext_key=0;
  - o_sched_done=0, o_err_timeout=0;
  - o_rk_valid=0, o_rk=0, o_rk_index=0, o_rk_last=0.
- The rk array is not reset; it is only read in DONE.
- Key load:
  - key accepted at edge N → o_ext_valid high during cycle N+1 with o_ext_i=0.
  - i_ext_valid sampled at edge M → next o_ext_valid high during cycle M+1.
  - Each round therefore takes L+1 cycles, where L is the expander latency.
- Completion: rk31 captured at edge M31 → o_sched_done=1 from cycle M31+1.
- Timeout: ERR is entered at the edge where the WAIT count equals TIMEOUT_CYC, i.e. TIMEOUT_CYC cycles with no result.
- Stream:
  - i_rk_start sampled at edge S → o_rk_valid=1 from cycle S+1.
  - With i_rk_ready held at 1, the stream delivers one key per cycle, 32 cycles total.
  - o_rk_valid falls in the cycle after the last handshake.
- Reset mid-schedule or mid-stream: everything returns to the reset values at the next edge. Any in-flight expander result is ignored.

## Test plan
- Standard key vector, with the real expander (L=4):
  - stimulus: i_key=0123456789ABCDEFFEDCBA9876543210;
  - required: rk0=F12186F9, rk1=41662B61, rk31=9124A012;
  - required: o_sched_done rises exactly 32·(L+1) cycles after the load edge;
  - required: o_ext_key is held stable throughout each WAIT.
- Encrypt stream with i_rk_ready=1: indices 0..31 in consecutive cycles; o_rk_last only at index 31.
- Decrypt stream with i_rk_ready toggling 1/0: first key is rk31=9124A012; o_rk holds during stalls; o_rk_last at index 0; exactly 32 handshakes.
- Timeout, TIMEOUT_CYC=16:
  - stimulus: expander model never returns i_ext_valid;
  - required: o_err_timeout=1 after 16 WAIT cycles;
  - required: a new key load clears the error and completes a correct schedule.
- Stray and ignored inputs:
  - an i_ext_valid pulse in IDLE or DONE changes nothing;
  - i_rk_start mid-stream or before DONE is ignored;
  - i_key_valid during an active stream sees o_key_ready=0.
- Reset mid-operation:
  - i_rst=0 for one cycle at round 10, then at stream index 5;
  - required: all outputs return to their reset values;
  - required: a subsequent load of the standard key reproduces the standard-vector round keys.
